stoch_signed_decoder: RTL and testbench
=======================================

# stoch_signed_decoder

Converts per-channel signed stochastic bitstream pairs (x_p, x_m) into signed fixed-point counts by accumulating p−m over a fixed window of valid samples. Sits at the output end of the stochastic pipeline, after stoch_signed_maxpool and similar layers, and turns bitstream layer outputs into binary words for host readout or requantization. The encoding is bipolar: the decoded value equals y / WINDOW.

## Interface
Parameters:
- CHANNELS, 3, number of independent stream pairs.
- WINDOW, 256, valid samples per decode window; must be ≥ 2 and need not be a power of two.
- CNT_W (localparam), $clog2(WINDOW+1), width of the sample counter.
- OUT_W (localparam), $clog2(WINDOW+1)+1, signed width of each result.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  begins one decode window when the block is idle.
- in_valid  input  1  the x_p/x_m bits on this cycle are a sample.
- x_p  input  [CHANNELS-1:0]  positive stream bit per channel.
- x_m  input  [CHANNELS-1:0]  negative stream bit per channel.
- y  output  [CHANNELS-1:0][OUT_W-1:0] signed  decoded count per channel, in the range −WINDOW..+WINDOW.
- y_valid  output  1  one-cycle pulse when y has just been updated.
- busy  output  1  high while a window is being accumulated.

## Operation
- FSM has two states:
  - IDLE: busy=0; start=1 moves to ACCUM and clears the sample counter and all accumulators.
  - ACCUM: busy=1; every cycle with in_valid=1 increments the counter and adds delta[c] = x_p[c] − x_m[c] (in {−1, 0, +1}) to acc[c]. Both x_p and x_m high, or both low, gives 0.
- When the valid sample that makes the count equal WINDOW is taken, the block copies the final acc values into y (including that last sample), pulses y_valid and returns to IDLE.
- y holds its value until the next y_valid. Cycles in ACCUM with in_valid=0 change nothing, so the window stretches.
- start is ignored while in ACCUM. start and in_valid together in IDLE: that cycle's sample is not counted.
- Arithmetic: accumulators are signed OUT_W bits. |acc| ≤ WINDOW, so they can never overflow and no saturation logic exists.
- Reset at any time, including mid-window: state returns to IDLE, all accumulators, y and the counter go to 0, y_valid=0, busy=0. The partial window is discarded.

## Timing
- Reset values: y=0, y_valid=0, busy=0.
- start sampled high at edge 0 → busy=1 from cycle 1. Samples are taken in cycles 1..N, where N ≥ WINDOW depends on in_valid.
- y and y_valid are registered. They become visible in the cycle after the last counted sample; with no stalls, latency from start to y_valid is WINDOW+1 cycles.
- busy falls in the same cycle that y_valid rises.
- No combinational path from any input to any output.

## Configuration
- Macro STOCH_DEC_CONTINUOUS_EN:
  - Defined: after the first start the block stays in ACCUM indefinitely. On the y_valid cycle a new window begins, with accumulators reloaded with that cycle's delta if in_valid=1, so there is no dead cycle. busy stays 1 and start has no further effect. RST still returns the block to IDLE.
  - Undefined: one-shot behaviour as described above.

## Structure
- Package stoch_pkg holds:
  - a typedef for the FSM state enum (IDLE, ACCUM);
  - the width functions used to derive CNT_W and OUT_W;
  - a typedef for the signed per-channel result word.
- Sub-module stoch_signed_updown: one per channel, created in a generate loop. It is a signed up/down accumulator with ports clear, load and en and inputs p and m.
- The top level owns the FSM, the sample counter and the y/y_valid registers.

## Test plan
- WINDOW=16, CHANNELS=3; ch0 p=1/m=0, ch1 p=0/m=1, ch2 p=m=1; in_valid=1; start at cycle 0 → y_valid at cycle 17 with y = {+16, −16, 0}; busy=1 in cycles 1–16.
- Ch0 fed an 8-of-16 random-position p stream with m=0 → y[0]=+8. Then a p stream with 4 ones and an m stream with 12 ones → y[0]=−8.
- in_valid toggled 1,0,1,0… with all p=1 → y_valid at cycle 32, y[0]=+16. Assert start again mid-window → no effect.
- Assert RST at cycle 9 mid-window → next cycle y=0, busy=0, no y_valid. A fresh start afterwards gives a correct +16.
- start and in_valid together while idle → first sample excluded. Feed p=1 only on that cycle and 0 afterwards → y[0]=0.
- With STOCH_DEC_CONTINUOUS_EN: constant p=1 → y_valid pulses every 16 cycles (17, 33, 49…), each with y[0]=+16, and busy never drops.

Source files
------------

// File: rtl/stoch_pkg.sv
// rtl/stoch_pkg.sv - shared types and width helpers for the stochastic decoder
package stoch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

    function automatic int out_width(input int window);
        return $clog2(window + 1) + 1;
    endfunction

    localparam int DEFAULT_WINDOW = 256;

    typedef logic signed [out_width(DEFAULT_WINDOW)-1:0] stoch_word_t;

endpackage

// File: rtl/stoch_signed_updown.sv
// rtl/stoch_signed_updown.sv - signed up/down accumulator for one bitstream pair
module stoch_signed_updown
    import stoch_pkg::*;
#(
    parameter int W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic                en,
    input  logic                p,
    input  logic                m,
    output logic signed [W-1:0] sum
);

    logic signed [W-1:0] acc_q, acc_d;
    logic signed [W-1:0] delta;

    always_comb begin
        delta = '0;
        if (p && !m) begin
            delta = W'(1);
        end else if (!p && m) begin
            delta = {W{1'b1}};
        end
    end

    // load restarts the window, keeping this cycle's sample if it is valid
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (load) begin
            acc_d = en ? delta : '0;
        end else if (en) begin
            acc_d = acc_q + delta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign sum = acc_d;

endmodule

// File: rtl/stoch_signed_decoder.sv
// rtl/stoch_signed_decoder.sv - windowed p-m count decoder; STOCH_DEC_CONTINUOUS_EN selects free-running windows
module stoch_signed_decoder
    import stoch_pkg::*;
#(
    parameter  int CHANNELS = 3,
    parameter  int WINDOW   = 256,
    localparam int CNT_W    = cnt_width(WINDOW),
    localparam int OUT_W    = out_width(WINDOW)
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   start,
    input  logic                                   in_valid,
    input  logic [CHANNELS-1:0]                    x_p,
    input  logic [CHANNELS-1:0]                    x_m,
    output logic signed [CHANNELS-1:0][OUT_W-1:0]  y,
    output logic                                   y_valid,
    output logic                                   busy
);

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic signed [CHANNELS-1:0][OUT_W-1:0] y_q, y_d;
    logic                                 y_valid_q;
    logic                                 take, last, start_acc, load;
    logic signed [OUT_W-1:0]              acc_next [CHANNELS];

    assign start_acc = (state_q == IDLE) && start;
    assign take      = (state_q == ACCUM) && in_valid;
    assign last      = take && (cnt_q == CNT_W'(WINDOW - 1));

`ifdef STOCH_DEC_CONTINUOUS_EN
    assign load = y_valid_q && (state_q == ACCUM);
`else
    assign load = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
`ifndef STOCH_DEC_CONTINUOUS_EN
                if (last) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ACCUM);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start_acc || last) begin
            cnt_d = '0;
        end else if (take) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        y_d = y_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (last) begin
                y_d[c] = acc_next[c];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_valid_q <= last;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        stoch_signed_updown #(.W(OUT_W)) u_acc (
            .clk   (CLK),
            .rst   (RST),
            .clear (start_acc),
            .load  (load),
            .en    (take),
            .p     (x_p[c]),
            .m     (x_m[c]),
            .sum   (acc_next[c])
        );
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_stoch_signed_decoder.sv
// tb/tb_stoch_signed_decoder.sv - randomized self-checking bench for stoch_signed_decoder
module tb_stoch_signed_decoder;

    localparam int CH     = 3;
    localparam int WINDOW = 16;
    localparam int OUT_W  = $clog2(WINDOW + 1) + 1;

    logic                               CLK = 1'b0;
    logic                               RST = 1'b1;
    logic                               start = 1'b0;
    logic                               in_valid = 1'b0;
    logic [CH-1:0]                      x_p = '0;
    logic [CH-1:0]                      x_m = '0;
    logic signed [CH-1:0][OUT_W-1:0]    y;
    logic                               y_valid;
    logic                               busy;

    int total = 0;
    int bad   = 0;

    logic [CH-1:0] p_q[$];
    logic [CH-1:0] m_q[$];
    bit            v_q[$];

    stoch_signed_decoder #(.CHANNELS(CH), .WINDOW(WINDOW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .in_valid (in_valid),
        .x_p      (x_p),
        .x_m      (x_m),
        .y        (y),
        .y_valid  (y_valid),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    function automatic int ych(input int c);
        logic signed [OUT_W-1:0] v;
        v = y[c];
        return int'(v);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_stim();
        p_q.delete();
        m_q.delete();
        v_q.delete();
    endtask

    // Append random samples until the sequence holds at least WINDOW valid ones.
    task automatic gen_random(input int valid_pct);
        int nv = 0;
        while (nv < WINDOW) begin
            bit v;
            v = ($urandom_range(99) < valid_pct);
            p_q.push_back(CH'($urandom));
            m_q.push_back(CH'($urandom));
            v_q.push_back(v);
            if (v) nv++;
        end
    endtask

    // One-shot window: expected y is the sum of p-m over the first WINDOW valid samples.
    task automatic run_window(input string name, input int extra_start_at,
                              input bit start_valid, input logic [CH-1:0] start_p);
        int  cnt = 0;
        int  sum [CH];
        bit  done = 0;
        int  held [CH];
        for (int c = 0; c < CH; c++) sum[c] = 0;
        start = 1'b1; in_valid = start_valid; x_p = start_p; x_m = '0;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || y_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s start: busy=%b y_valid=%b required busy=1 y_valid=0", name, busy, y_valid);
        end
        for (int i = 0; i < v_q.size() && !done; i++) begin
            in_valid = v_q[i]; x_p = p_q[i]; x_m = m_q[i];
            start = (i == extra_start_at);
            if (v_q[i]) begin
                cnt++;
                for (int c = 0; c < CH; c++) sum[c] += int'(p_q[i][c]) - int'(m_q[i][c]);
            end
            tick();
            start = 1'b0;
            total++;
            if (cnt == WINDOW) begin
                done = 1;
                if (y_valid !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s end: y_valid=%b busy=%b required 1/0 at cycle %0d", name, y_valid, busy, i + 2);
                end
                for (int c = 0; c < CH; c++) begin
                    total++;
                    if (ych(c) !== sum[c]) begin
                        bad++;
                        $display("FAIL %s y[%0d]: got %0d required %0d", name, c, ych(c), sum[c]);
                    end
                end
            end else if (y_valid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL %s mid: y_valid=%b busy=%b required 0/1 at cycle %0d", name, y_valid, busy, i + 2);
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: only %0d valid samples, required %0d", name, cnt, WINDOW);
        end
        for (int c = 0; c < CH; c++) held[c] = sum[c];
        in_valid = 1'b1; x_p = '1; x_m = '0;
        tick();
        tick();
        in_valid = 1'b0;
        total++;
        if (y_valid !== 1'b0 || busy !== 1'b0 || ych(0) !== held[0]) begin
            bad++;
            $display("FAIL %s hold: y_valid=%b busy=%b y0=%0d required 0/0/%0d", name, y_valid, busy, ych(0), held[0]);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        total++;
        if (y !== '0 || y_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: y=%h y_valid=%b busy=%b required 0/0/0", y, y_valid, busy);
        end
    endtask

`ifndef STOCH_DEC_CONTINUOUS_EN
    task automatic test_directed();
        clear_stim();
        for (int i = 0; i < WINDOW; i++) begin
            p_q.push_back(3'b101); m_q.push_back(3'b110); v_q.push_back(1'b1);
        end
        run_window("directed", -1, 1'b0, '0);
    endtask

    task automatic test_density();
        bit pos [WINDOW];
        bit mpos [WINDOW];
        for (int i = 0; i < WINDOW; i++) pos[i] = (i < 8);
        for (int i = WINDOW - 1; i > 0; i--) begin
            int j; bit t;
            j = $urandom_range(i); t = pos[i]; pos[i] = pos[j]; pos[j] = t;
        end
        clear_stim();
        for (int i = 0; i < WINDOW; i++) begin
            p_q.push_back({CH'($urandom)} & ~CH'(1) | CH'(pos[i]));
            m_q.push_back({CH'($urandom)} & ~CH'(1));
            v_q.push_back(1'b1);
        end
        run_window("density8", -1, 1'b0, '0);
        for (int i = 0; i < WINDOW; i++) begin
            pos[i] = (i < 4); mpos[i] = (i < 12);
        end
        for (int i = WINDOW - 1; i > 0; i--) begin
            int j; bit t;
            j = $urandom_range(i); t = pos[i]; pos[i] = pos[j]; pos[j] = t;
            j = $urandom_range(i); t = mpos[i]; mpos[i] = mpos[j]; mpos[j] = t;
        end
        clear_stim();
        for (int i = 0; i < WINDOW; i++) begin
            p_q.push_back(CH'(pos[i])); m_q.push_back(CH'(mpos[i])); v_q.push_back(1'b1);
        end
        run_window("density_neg", -1, 1'b0, '0);
    endtask

    task automatic test_stall();
        clear_stim();
        for (int i = 0; i < 2 * WINDOW; i++) begin
            p_q.push_back('1); m_q.push_back('0); v_q.push_back((i % 2) == 0);
        end
        run_window("stall_alt", 10, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            clear_stim();
            gen_random(40 + 20 * k);
            run_window("stall_rand", $urandom_range(WINDOW), 1'b0, '0);
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; x_p = '1; x_m = '0;
        for (int i = 0; i < 8; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; in_valid = 1'b1;
        total++;
        if (y !== '0 || busy !== 1'b0 || y_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: y=%h busy=%b y_valid=%b required 0/0/0", y, busy, y_valid);
        end
        for (int i = 0; i < WINDOW + 2; i++) begin
            tick();
            total++;
            if (y_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset idle: y_valid=%b busy=%b required 0/0", y_valid, busy);
            end
        end
        in_valid = 1'b0;
        clear_stim();
        for (int i = 0; i < WINDOW; i++) begin
            p_q.push_back('1); m_q.push_back('0); v_q.push_back(1'b1);
        end
        run_window("after_reset", -1, 1'b0, '0);
    endtask

    task automatic test_start_with_valid();
        clear_stim();
        for (int i = 0; i < WINDOW; i++) begin
            p_q.push_back('0); m_q.push_back('0); v_q.push_back(1'b1);
        end
        run_window("start_valid", -1, 1'b1, '1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            clear_stim();
            gen_random($urandom_range(30, 100));
            run_window("random", -1, 1'b1, CH'($urandom));
        end
    endtask
`else
    // Free-running: each group of WINDOW valid samples yields one y_valid with its own sum.
    task automatic test_continuous();
        int cnt = 0;
        int sum [CH];
        int pulses = 0;
        for (int c = 0; c < CH; c++) sum[c] = 0;
        start = 1'b1; in_valid = 1'b0; tick(); start = 1'b0;
        for (int i = 0; i < 8 * WINDOW; i++) begin
            if (i < 3 * WINDOW) begin
                in_valid = 1'b1; x_p = '1; x_m = '0;
            end else begin
                in_valid = ($urandom_range(99) < 70); x_p = CH'($urandom); x_m = CH'($urandom);
            end
            start = ($urandom_range(9) == 0);
            if (in_valid) begin
                cnt++;
                for (int c = 0; c < CH; c++) sum[c] += int'(x_p[c]) - int'(x_m[c]);
            end
            tick();
            total++;
            if (cnt == WINDOW) begin
                pulses++;
                if (y_valid !== 1'b1 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL cont end: y_valid=%b busy=%b required 1/1 at cycle %0d", y_valid, busy, i + 2);
                end
                for (int c = 0; c < CH; c++) begin
                    total++;
                    if (ych(c) !== sum[c]) begin
                        bad++;
                        $display("FAIL cont y[%0d]: got %0d required %0d", c, ych(c), sum[c]);
                    end
                    sum[c] = 0;
                end
                cnt = 0;
            end else if (y_valid !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL cont mid: y_valid=%b busy=%b required 0/1 at cycle %0d", y_valid, busy, i + 2);
            end
        end
        start = 1'b0; in_valid = 1'b0;
        total++;
        if (pulses < 5) begin
            bad++;
            $display("FAIL cont pulses: got %0d required at least 5", pulses);
        end
        RST = 1'b1; tick(); RST = 1'b0;
        total++;
        if (busy !== 1'b0 || y !== '0) begin
            bad++;
            $display("FAIL cont reset: busy=%b y=%h required 0/0", busy, y);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef STOCH_DEC_CONTINUOUS_EN
        test_directed();
        test_density();
        test_stall();
        test_mid_reset();
        test_start_with_valid();
        test_random();
`else
        test_continuous();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
